decoder_2to4: RTL and testbench
===============================

// Module: decoder_2to4
// PURPOSE
//   Registered 2-to-4 one-hot line decoder with enable. Input code {a,b} (a = MSB)
//   selects exactly one of four output lines, captured on the clock edge. Used as
//   a select/strobe generator feeding chip-select or mux-select logic downstream.
// PARAMETERS
//   CNT_W   default 8   width of each per-line hit counter (used only with DECODER_2TO4_HITCNT_EN)
// PORTS
//   clk      in   1        system clock, all state updates on rising edge
//   rst      in   1        reset, asynchronous, active-high
//   en       in   1        decode enable; 0 forces all lines inactive
//   a        in   1        code bit 1 (MSB)
//   b        in   1        code bit 0 (LSB)
//   y        out  4        registered one-hot decoded output
//   y_valid  out  1        registered; 1 when y holds a decoded code
//   hit_cnt  out  4*CNT_W  per-line hit counters (present only with DECODER_2TO4_HITCNT_EN)
// BEHAVIOUR
//   - One clock domain (clk). Reset is asynchronous, active-high. While rst=1:
//     y=4'b0000, y_valid=0, all hit counters=0. Release takes effect at the next rising edge.
//   - Decode table, code={a,b}: 00->0001, 01->0010, 10->0100, 11->1000 (y = 4'b0001 << code).
//   - Latency: 1 cycle. At the rising edge with en=1: y <= decode({a,b}), y_valid <= 1.
//   - At the rising edge with en=0: y <= 4'b0000, y_valid <= 0.
//   - Invariant: y is one-hot when y_valid=1 and all-zero when y_valid=0; never multi-hot.
//   - Inputs a/b/en are sampled only at the clock edge; changes between edges have
//     no effect on y. There is no combinational path from inputs to outputs.
//   - Any X/Z on a or b while en=1 produces y=0000, y_valid=0 in simulation
//     (synthesis treats it as don't-care). X/Z on en is treated as en=0.
//   - Reset asserted mid-operation clears y, y_valid and counters immediately,
//     without waiting for a clock edge.
//   - Repeated identical codes keep y stable (no glitch, no toggle).
// CONFIGURATION
//   - Macro DECODER_2TO4_HITCNT_EN defined: hit_cnt port exists. Four CNT_W-bit counters,
//     line k in hit_cnt[k*CNT_W +: CNT_W]. Counter k increments by 1 at each rising
//     edge where en=1 and {a,b}==k. Saturates at 2**CNT_W-1 (no wrap). Cleared by rst.
//     Counters are registered and reflect the same edge that updates y.
//   - Macro undefined: hit_cnt port and counters absent; CNT_W unused; decode
//     behaviour identical cycle-for-cycle.
// TESTING
//   - Assert rst at t=0, hold 2 cycles -> y=0000, y_valid=0 (and hit_cnt=0 if enabled).
//   - en=1, sweep {a,b}=00,01,10,11 one per cycle -> y=0001,0010,0100,1000, each
//     one cycle after the code is applied; y_valid=1 throughout.
//   - en=0 with {a,b}=11 -> next edge y=0000, y_valid=0; re-enable -> y=1000 next edge.
//   - Assert rst asynchronously mid-cycle while y=0100 -> y=0000 and y_valid=0 before the next edge.
//   - Toggle a/b between clock edges only -> y unchanged until the next rising edge.
//   - With DECODER_2TO4_HITCNT_EN, CNT_W=8: hold {a,b}=10, en=1 for 300 cycles ->
//     hit_cnt line2=255 (saturated), lines 0,1,3 = 0.

Source files
------------

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 one-hot decoder with enable and an invalid-code guard.
// Define DECODER_2TO4_HITCNT_EN to add saturating per-line hit counters on hit_cnt.
module decoder_2to4 #(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                a,
    input  logic                b,
    output logic [3:0]          y,
    output logic                y_valid
`ifdef DECODER_2TO4_HITCNT_EN
    ,
    output logic [4*CNT_W-1:0]  hit_cnt
`endif
);

    // A counter width below one bit cannot hold any hits.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("decoder_2to4: CNT_W must be at least 1");
    end

    // Any code outside the four legal values (X/Z in simulation) yields no line.
    function automatic logic [3:0] decode_onehot(input logic [1:0] code);
        logic [3:0] line;
        case (code)
            2'b00:   line = 4'b0001;
            2'b01:   line = 4'b0010;
            2'b10:   line = 4'b0100;
            2'b11:   line = 4'b1000;
            default: line = 4'b0000;
        endcase
        return line;
    endfunction

    logic [3:0] y_next_s;
    logic       valid_next_s;
    logic [3:0] y_r;
    logic       valid_r;

    // Next-state decode; an unknown enable falls into the default (disabled) arm.
    always_comb begin
        y_next_s     = 4'b0000;
        valid_next_s = 1'b0;
        case (en)
            1'b1: begin
                y_next_s     = decode_onehot({a, b});
                valid_next_s = |y_next_s;
            end
            default: begin
                y_next_s     = 4'b0000;
                valid_next_s = 1'b0;
            end
        endcase
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r     <= 4'b0000;
            valid_r <= 1'b0;
        end else begin
            y_r     <= y_next_s;
            valid_r <= valid_next_s;
        end
    end

    assign y       = y_r;
    assign y_valid = valid_r;

`ifdef DECODER_2TO4_HITCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r [4];

    for (genvar k = 0; k < 4; k++) begin : g_hit
        // Saturating hit counter for line k, updated on the same edge as y.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r[k] <= {CNT_W{1'b0}};
            end else if (valid_next_s && y_next_s[k] && (cnt_r[k] != CNT_MAX)) begin
                cnt_r[k] <= cnt_r[k] + CNT_ONE;
            end else begin
                cnt_r[k] <= cnt_r[k];
            end
        end

        assign hit_cnt[k*CNT_W +: CNT_W] = cnt_r[k];
    end
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
// Directed, table-driven bench for decoder_2to4, plus hand-written sequences for
// asynchronous reset, between-edge input toggling and (when enabled) hit counter saturation.
module tb_decoder_2to4;

    localparam int CNT_W = 8;

    logic       clk;
    logic       rst;
    logic       en;
    logic       a;
    logic       b;
    logic [3:0] y;
    logic       y_valid;
`ifdef DECODER_2TO4_HITCNT_EN
    logic [4*CNT_W-1:0] hit_cnt;
`endif

    int n_chk;
    int n_fail;

    decoder_2to4 #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a),
        .b       (b),
        .y       (y),
        .y_valid (y_valid)
`ifdef DECODER_2TO4_HITCNT_EN
        ,
        .hit_cnt (hit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] code;
        logic [3:0] exp_y;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic e, input logic [1:0] code);
        @(negedge clk);
        en = e;
        a  = code[1];
        b  = code[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        vecs[0]  = '{1'b1, 2'b00, 4'b0001, 1'b1};
        vecs[1]  = '{1'b1, 2'b01, 4'b0010, 1'b1};
        vecs[2]  = '{1'b1, 2'b10, 4'b0100, 1'b1};
        vecs[3]  = '{1'b1, 2'b11, 4'b1000, 1'b1};
        vecs[4]  = '{1'b0, 2'b11, 4'b0000, 1'b0};
        vecs[5]  = '{1'b1, 2'b11, 4'b1000, 1'b1};
        vecs[6]  = '{1'b1, 2'b11, 4'b1000, 1'b1};
        vecs[7]  = '{1'b1, 2'b00, 4'b0001, 1'b1};
        vecs[8]  = '{1'b0, 2'b00, 4'b0000, 1'b0};
        vecs[9]  = '{1'b1, 2'b10, 4'b0100, 1'b1};
        vecs[10] = '{1'b0, 2'b01, 4'b0000, 1'b0};
        vecs[11] = '{1'b1, 2'b01, 4'b0010, 1'b1};

        // Reset held for two cycles with the decoder enabled on a legal code.
        rst = 1'b1;
        en  = 1'b1;
        a   = 1'b1;
        b   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", {28'd0, y}, 32'h0);
        chk("reset_valid", {31'd0, y_valid}, 32'h0);
`ifdef DECODER_2TO4_HITCNT_EN
        chk("reset_hit_cnt", hit_cnt, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;

        // Table sweep.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].en, vecs[i].code);
            chk($sformatf("vec%0d_y", i), {28'd0, y}, {28'd0, vecs[i].exp_y});
            chk($sformatf("vec%0d_valid", i), {31'd0, y_valid}, {31'd0, vecs[i].exp_valid});
        end

        // Asynchronous reset mid-cycle while y=0100.
        step(1'b1, 2'b10);
        chk("pre_async_y", {28'd0, y}, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_y", {28'd0, y}, 32'h0);
        chk("async_rst_valid", {31'd0, y_valid}, 32'h0);
`ifdef DECODER_2TO4_HITCNT_EN
        chk("async_rst_hit_cnt", hit_cnt, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 2'b10);
        chk("post_rst_y", {28'd0, y}, 32'h4);
        chk("post_rst_valid", {31'd0, y_valid}, 32'h1);

        // Toggling a/b between edges must not disturb y.
        step(1'b1, 2'b00);
        chk("toggle_base_y", {28'd0, y}, 32'h1);
        for (int i = 1; i < 4; i++) begin
            a = i[1];
            b = i[0];
            #1;
            chk($sformatf("toggle%0d_y", i), {28'd0, y}, 32'h1);
        end
        step(1'b1, 2'b01);
        chk("toggle_after_edge_y", {28'd0, y}, 32'h2);

`ifdef DECODER_2TO4_HITCNT_EN
        // Counter saturation on line 2.
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 2'b10);
        chk("hit_line2_5", {24'd0, hit_cnt[2*CNT_W +: CNT_W]}, 32'd5);
        for (int i = 5; i < 300; i++) step(1'b1, 2'b10);
        chk("hit_line0_sat", {24'd0, hit_cnt[0*CNT_W +: CNT_W]}, 32'd0);
        chk("hit_line1_sat", {24'd0, hit_cnt[1*CNT_W +: CNT_W]}, 32'd0);
        chk("hit_line2_sat", {24'd0, hit_cnt[2*CNT_W +: CNT_W]}, 32'd255);
        chk("hit_line3_sat", {24'd0, hit_cnt[3*CNT_W +: CNT_W]}, 32'd0);
        step(1'b0, 2'b11);
        chk("hit_disabled_line3", {24'd0, hit_cnt[3*CNT_W +: CNT_W]}, 32'd0);
        step(1'b1, 2'b11);
        chk("hit_line3_one", {24'd0, hit_cnt[3*CNT_W +: CNT_W]}, 32'd1);
        chk("hit_line2_hold", {24'd0, hit_cnt[2*CNT_W +: CNT_W]}, 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
